// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the 16550-style UART transmitter.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int OVERSAMPLE_DEFAULT = 16;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    // 1.5 stop bits exist only for 5-bit words; other lengths use 2 stop bits.
    function automatic int stop_ticks(input logic stb, input logic [1:0] wls, input int oversample);
        if (!stb)
            return oversample;
        else if (wls == WLS_5)
            return (oversample * 3) / 2;
        else
            return oversample * 2;
    endfunction

endpackage

// File: rtl/uart_tx_parity.sv
// Combinational parity for the bits actually sent (wls+5 LSBs), honouring stick parity.
module uart_tx_parity
    import uart_tx_pkg::*;
(
    input  logic [7:0] data,
    input  logic [1:0] wls,
    input  logic       sticky,
    input  logic       eps,
    output logic       parity
);

    logic [7:0] mask;
    logic       data_xor;

    always_comb begin
        mask = 8'hFF;
        case (wls)
            WLS_5: mask = 8'h1F;
            WLS_6: mask = 8'h3F;
            WLS_7: mask = 8'h7F;
            WLS_8: mask = 8'hFF;
        endcase
        data_xor = ^(data & mask);
        if (sticky)
            parity = ~eps;
        else if (eps)
            parity = data_xor;
        else
            parity = ~data_xor;
    end

endmodule

// File: rtl/uart_tx_top.sv
// UART transmit serialiser: start, 5-8 data bits LSB first, optional parity, 1/1.5/2 stops.
// Line break forcing is compiled in only when UART_TX_BREAK_EN is defined.
module uart_tx_top
    import uart_tx_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_pulse,
    input  logic       parity_enable,
    input  logic       tx_hold_reg_empty,
    input  logic       stop_bit,
    input  logic       sticky_parity,
    input  logic       even_parity_select,
    input  logic       set_break,
    input  logic [7:0] din,
    input  logic [1:0] wls,
    output logic       pop,
    output logic       sreg_empty,
    output logic       tx
);

    localparam int CNT_W = $clog2(2 * OVERSAMPLE);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(OVERSAMPLE - 1);

    tx_state_t        state;
    logic [CNT_W-1:0] tick_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       sh_data;
    logic [1:0]       sh_wls;
    logic             sh_pen;
    logic             sh_stb;
    logic             sh_sticky;
    logic             sh_eps;
    logic             tx_reg;
    logic             parity_bit;
    logic [2:0]       last_bit;
    logic [CNT_W-1:0] stop_last;

    assign last_bit  = {1'b0, sh_wls} + 3'd4;
    assign stop_last = CNT_W'(stop_ticks(sh_stb, sh_wls, OVERSAMPLE) - 1);

    uart_tx_parity u_parity (
        .data   (sh_data),
        .wls    (sh_wls),
        .sticky (sh_sticky),
        .eps    (sh_eps),
        .parity (parity_bit)
    );

    // Frame sequencer; line config is shadowed at load so later LCR writes cannot corrupt a frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            tx_reg     <= 1'b1;
            pop        <= 1'b0;
            sreg_empty <= 1'b1;
            sh_data    <= '0;
            sh_wls     <= '0;
            sh_pen     <= 1'b0;
            sh_stb     <= 1'b0;
            sh_sticky  <= 1'b0;
            sh_eps     <= 1'b0;
        end else begin
            pop <= 1'b0;
            if (baud_pulse) begin
                case (state)
                    IDLE: begin
                        tx_reg     <= 1'b1;
                        sreg_empty <= 1'b1;
                        if (!tx_hold_reg_empty) begin
                            sh_data    <= din;
                            sh_wls     <= wls;
                            sh_pen     <= parity_enable;
                            sh_stb     <= stop_bit;
                            sh_sticky  <= sticky_parity;
                            sh_eps     <= even_parity_select;
                            pop        <= 1'b1;
                            sreg_empty <= 1'b0;
                            tx_reg     <= 1'b0;
                            tick_cnt   <= '0;
                            bit_cnt    <= '0;
                            state      <= START;
                        end
                    end
                    START: begin
                        if (tick_cnt == BIT_LAST) begin
                            tick_cnt <= '0;
                            tx_reg   <= sh_data[0];
                            state    <= DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (tick_cnt == BIT_LAST) begin
                            tick_cnt <= '0;
                            if (bit_cnt == last_bit) begin
                                if (sh_pen) begin
                                    tx_reg <= parity_bit;
                                    state  <= PARITY;
                                end else begin
                                    tx_reg <= 1'b1;
                                    state  <= STOP;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                tx_reg  <= sh_data[bit_cnt + 3'd1];
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        if (tick_cnt == BIT_LAST) begin
                            tick_cnt <= '0;
                            tx_reg   <= 1'b1;
                            state    <= STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (tick_cnt == stop_last) begin
                            tick_cnt   <= '0;
                            sreg_empty <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef UART_TX_BREAK_EN
    assign tx = tx_reg & ~set_break;
`else
    logic unused_set_break;
    assign unused_set_break = set_break;
    assign tx = tx_reg;
`endif

endmodule

// File: tb/tb_uart_tx_top.sv
// Scoreboard bench for uart_tx_top: directed frames, decoded from the line by a monitor.
module tb_uart_tx_top;

    localparam int OS       = 16;
    localparam int LINE_MAX = 256;

    typedef struct {
        logic [7:0] data;
        int         nbits;
        bit         has_par;
        bit         par;
        int         len;
        bit         skip_data;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_pulse;
    logic       parity_enable;
    logic       tx_hold_reg_empty;
    logic       stop_bit;
    logic       sticky_parity;
    logic       even_parity_select;
    logic       set_break;
    logic [7:0] din;
    logic [1:0] wls;
    logic       pop;
    logic       sreg_empty;
    logic       tx;

    int     tests_run    = 0;
    int     tests_failed = 0;
    frame_t exp_q[$];
    bit     line[LINE_MAX];
    bit     skip_next = 0;

    uart_tx_top #(.OVERSAMPLE(OS)) dut (
        .clk                (clk),
        .rst                (rst),
        .baud_pulse         (baud_pulse),
        .parity_enable      (parity_enable),
        .tx_hold_reg_empty  (tx_hold_reg_empty),
        .stop_bit           (stop_bit),
        .sticky_parity      (sticky_parity),
        .even_parity_select (even_parity_select),
        .set_break          (set_break),
        .din                (din),
        .wls                (wls),
        .pop                (pop),
        .sreg_empty         (sreg_empty),
        .tx                 (tx)
    );

    always #5 clk = ~clk;

    // A baud tick every second clock leaves non-tick cycles for pop to fall on.
    initial begin
        baud_pulse = 1'b0;
        forever begin
            @(negedge clk);
            baud_pulse = ~baud_pulse;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int required);
        tests_run++;
        if (actual !== required) begin
            tests_failed++;
            $display("[TB] FAIL %s: actual %0d required %0d", name, actual, required);
        end
    endtask

    task automatic checkFrame(input int len, input int pops);
        frame_t     e;
        logic [7:0] got;
        bit         stop_ok;
        int         first_stop;
        if (exp_q.size() == 0) begin
            checkOutput("frame_expected", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        checkOutput("frame_len", len, e.len);
        checkOutput("frame_pops", pops, 1);
        checkOutput("start_bit", int'(line[OS/2]), 0);
        if (!e.skip_data) begin
            got = '0;
            for (int i = 0; i < e.nbits; i++)
                got[i] = line[(1 + i) * OS + OS/2];
            checkOutput("data_bits", int'(got), int'(e.data));
        end
        if (e.has_par)
            checkOutput("parity_bit", int'(line[(1 + e.nbits) * OS + OS/2]), int'(e.par));
        stop_ok    = 1'b1;
        first_stop = (1 + e.nbits + int'(e.has_par)) * OS;
        for (int k = first_stop; k <= len && k < LINE_MAX; k++)
            if (!line[k]) stop_ok = 1'b0;
        checkOutput("stop_high", int'(stop_ok), 1);
    endtask

    // Monitor: records the line after every tick of a frame, scores it when sreg_empty returns.
    initial begin : monitor
        bit in_frame;
        bit prev_empty;
        bit prev_pop;
        int tick_idx;
        int frame_pops;
        in_frame   = 1'b0;
        prev_empty = 1'b1;
        prev_pop   = 1'b0;
        tick_idx   = 0;
        frame_pops = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                in_frame   = 1'b0;
                prev_empty = 1'b1;
                prev_pop   = 1'b0;
            end else begin
                if (pop)
                    checkOutput("pop_one_clk", int'(prev_pop), 0);
                if (prev_empty && !sreg_empty) begin
                    in_frame   = 1'b1;
                    tick_idx   = 0;
                    line[0]    = tx;
                    frame_pops = int'(pop);
                end else if (in_frame) begin
                    if (pop) frame_pops++;
                    if (baud_pulse) begin
                        tick_idx++;
                        if (tick_idx < LINE_MAX) line[tick_idx] = tx;
                        if (sreg_empty || tick_idx >= LINE_MAX - 1) begin
                            in_frame = 1'b0;
                            checkFrame(tick_idx, frame_pops);
                        end
                    end
                end
                prev_empty = sreg_empty;
                prev_pop   = pop;
            end
        end
    end

    // Loads one byte; a zero expected length marks a frame that will be aborted.
    task automatic applyStimulus(input logic [7:0] d, input logic [1:0] w, input logic pen,
                                 input logic stb, input logic stick, input logic eps,
                                 input logic [7:0] exp_data, input int exp_bits,
                                 input bit exp_has_par, input bit exp_par, input int exp_len);
        frame_t e;
        bit     seen;
        if (exp_len != 0) begin
            e.data      = exp_data;
            e.nbits     = exp_bits;
            e.has_par   = exp_has_par;
            e.par       = exp_par;
            e.len       = exp_len;
            e.skip_data = skip_next;
            exp_q.push_back(e);
        end
        din                = d;
        wls                = w;
        parity_enable      = pen;
        stop_bit           = stb;
        sticky_parity      = stick;
        even_parity_select = eps;
        tx_hold_reg_empty  = 1'b0;
        seen               = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (pop) seen = 1'b1;
        end
        if (!seen) checkOutput("pop_timeout", 0, 1);
        din                = ~d;
        wls                = ~w;
        parity_enable      = ~pen;
        stop_bit           = ~stb;
        sticky_parity      = ~stick;
        even_parity_select = ~eps;
        tx_hold_reg_empty  = 1'b1;
    endtask

    task automatic waitIdle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            if (sreg_empty) done = 1'b1;
        end
        if (!done) checkOutput("frame_end_timeout", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin : stimulus
        int idle_pops;
        int idle_low;
        int idle_busy;
        bit brk_skip;
        bit brk_tx;
`ifdef UART_TX_BREAK_EN
        brk_skip = 1'b1;
        brk_tx   = 1'b0;
`else
        brk_skip = 1'b0;
        brk_tx   = 1'b1;
`endif
        rst                = 1'b0;
        parity_enable      = 1'b0;
        tx_hold_reg_empty  = 1'b1;
        stop_bit           = 1'b0;
        sticky_parity      = 1'b0;
        even_parity_select = 1'b0;
        set_break          = 1'b0;
        din                = 8'h00;
        wls                = 2'b00;
        repeat (4) @(negedge clk);
        checkOutput("reset_tx", int'(tx), 1);
        checkOutput("reset_pop", int'(pop), 0);
        checkOutput("reset_sreg_empty", int'(sreg_empty), 1);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        $display("[TB] frame tests");
        applyStimulus(8'hA4, 2'b11, 1, 1, 0, 1, 8'hA4, 8, 1, 1, 192); waitIdle();
        applyStimulus(8'h1F, 2'b00, 0, 1, 0, 1, 8'h1F, 5, 0, 0, 120); waitIdle();
        applyStimulus(8'h00, 2'b11, 1, 0, 0, 0, 8'h00, 8, 1, 1, 176); waitIdle();
        applyStimulus(8'h00, 2'b11, 1, 0, 1, 0, 8'h00, 8, 1, 1, 176); waitIdle();
        applyStimulus(8'h00, 2'b11, 1, 0, 1, 1, 8'h00, 8, 1, 0, 176); waitIdle();
        applyStimulus(8'hE5, 2'b01, 1, 1, 0, 1, 8'h25, 6, 1, 1, 160); waitIdle();

        $display("[TB] idle with empty holding register");
        idle_pops = 0;
        idle_low  = 0;
        idle_busy = 0;
        repeat (200) begin
            @(negedge clk);
            if (pop) idle_pops++;
            if (!tx) idle_low++;
            if (!sreg_empty) idle_busy++;
        end
        checkOutput("idle_pops", idle_pops, 0);
        checkOutput("idle_tx_low", idle_low, 0);
        checkOutput("idle_sreg_busy", idle_busy, 0);

        $display("[TB] break during data");
        skip_next = brk_skip;
        applyStimulus(8'hFF, 2'b11, 0, 0, 0, 0, 8'hFF, 8, 0, 0, 160);
        skip_next = 1'b0;
        repeat (70) @(negedge clk);
        set_break = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("break_tx", int'(tx), int'(brk_tx));
        checkOutput("break_sreg_empty", int'(sreg_empty), 0);
        set_break = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("break_release_tx", int'(tx), 1);
        waitIdle();

        $display("[TB] reset mid-frame");
        applyStimulus(8'h00, 2'b11, 0, 0, 0, 0, 8'h00, 8, 0, 0, 0);
        repeat (60) @(negedge clk);
        checkOutput("pre_reset_tx", int'(tx), 0);
        checkOutput("pre_reset_sreg_empty", int'(sreg_empty), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("mid_reset_tx", int'(tx), 1);
        checkOutput("mid_reset_sreg_empty", int'(sreg_empty), 1);
        checkOutput("mid_reset_pop", int'(pop), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        applyStimulus(8'h5A, 2'b10, 1, 0, 0, 0, 8'h5A, 7, 1, 1, 160); waitIdle();

        checkOutput("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
